word_serializer: RTL and testbench

//  - Upstream feeder for the serial two's-complement stage (invert).
//  - Accepts a parallel word on a valid/ready handshake and shifts it out LSB-first on ser_out.
//  - Drives frm_rst high between words so the complementer starts each word in its clear state.
//  - ser_out connects to the complementer bit input i; frm_rst connects to its reset input r.

---
 rtl/word_serializer_pkg.sv | 16 +
 rtl/word_skid_reg.sv | 26 ++
 rtl/word_serializer.sv | 106 ++++++++++
 tb/tb_word_serializer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM state encoding and WIDTH legality.
package word_serializer_pkg;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    function automatic bit width_legal(input int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/word_skid_reg.sv
// One-entry holding register with a full flag; parks a word accepted while the shifter is busy.
module word_skid_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             full
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            full <= 1'b0;
        end else if (push) begin
            q    <= d;
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder (LSB first) for the serial two's-complement stage.
// Optional one-entry input skid buffer enabled by defining SERIALIZER_SKID_EN.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             frm_rst,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);
    localparam logic [CW-1:0] ONE     = CW'(1);

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("word_serializer: WIDTH must be in 2..32");
    end

    ser_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             start;
    logic [WIDTH-1:0] load_word;

`ifdef SERIALIZER_SKID_EN
    logic             skid_full;
    logic             skid_push;
    logic             skid_pop;
    logic [WIDTH-1:0] skid_q;

    // A parked word has priority over din; din_ready stays low until it drains.
    assign din_ready = !skid_full;
    assign skid_push = (state == ST_SHIFT) && din_valid && !skid_full;
    assign skid_pop  = (state == ST_IDLE) && skid_full;
    assign start     = (state == ST_IDLE) && (skid_full || din_valid);
    assign load_word = skid_full ? skid_q : din;

    word_skid_reg #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk   (t_clk),
        .rst_n (r_n),
        .push  (skid_push),
        .pop   (skid_pop),
        .d     (din),
        .q     (skid_q),
        .full  (skid_full)
    );
`else
    assign din_ready = (state == ST_IDLE);
    assign start     = din_ready && din_valid;
    assign load_word = din;
`endif

    // Outputs are registered alongside the next state so they match the state they describe.
    always_ff @(posedge t_clk or negedge r_n) begin
        if (!r_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            shreg   <= '0;
            ser_out <= 1'b0;
            frm_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_SHIFT;
                        shreg   <= load_word;
                        cnt     <= '0;
                        ser_out <= load_word[0];
                        frm_rst <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg >> 1;
                    if (cnt == LAST) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        ser_out <= 1'b0;
                        frm_rst <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        cnt     <= cnt + ONE;
                        ser_out <= shreg[1];
                        done    <= (cnt == LAST_M1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Directed self-checking bench for word_serializer (WIDTH=8); skid scenarios under SERIALIZER_SKID_EN.
module tb_word_serializer;

    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         ser_out;
    logic         frm_rst;
    logic         busy;
    logic         done;

    int total = 0;
    int bad = 0;

    word_serializer #(
        .WIDTH(W)
    ) dut (
        .t_clk     (t_clk),
        .r_n       (r_n),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ser_out   (ser_out),
        .frm_rst   (frm_rst),
        .busy      (busy),
        .done      (done)
    );

    always #5 t_clk = ~t_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Bit-serial two's complement as the downstream stage computes it.
    function automatic logic [W-1:0] twos_serial(input logic [W-1:0] b);
        logic [W-1:0] r;
        logic seen;
        seen = 1'b0;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[i] = b[i] ^ seen;
            if (b[i]) seen = 1'b1;
        end
        return r;
    endfunction

    task automatic send_word(input logic [W-1:0] w, input string tag, output logic [W-1:0] got);
        int n;
        int dones;
        n = 0;
        dones = 0;
        got = '0;
        din = w;
        din_valid = 1'b1;
        while (!din_ready && n < 50) begin
            @(negedge t_clk);
            n++;
        end
        check({tag, "_accept"}, 32'(n < 50), 32'd1);
        @(negedge t_clk);
        din_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_frm"}, frm_rst, 0);
            check({tag, "_done"}, done, 32'(i == W - 1));
            got[i] = ser_out;
            dones += int'(done);
            @(negedge t_clk);
        end
        check({tag, "_gap_frm"}, frm_rst, 1);
        check({tag, "_gap_busy"}, busy, 0);
        check({tag, "_ndone"}, dones, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] g1;
        logic [W-1:0] g2;

        // 1. reset and idle
        r_n = 1'b0;
        repeat (2) @(posedge t_clk);
        @(negedge t_clk);
        check("rst_frm", frm_rst, 1);
        check("rst_ser", ser_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdy", din_ready, 1);
        r_n = 1'b1;
        repeat (3) @(negedge t_clk);
        check("idle_frm", frm_rst, 1);
        check("idle_busy", busy, 0);
        check("idle_rdy", din_ready, 1);

        // 2. single word
        send_word(8'h14, "w14", g1);
        check("w14_bits", g1, 8'h14);
        check("w14_inv", twos_serial(g1), 8'hEC);

        // 3. back-to-back with valid held high
        din = 8'h01;
        din_valid = 1'b1;
        @(negedge t_clk);
        din = 8'hFF;
        g1 = '0;
        for (int i = 0; i < W; i++) begin
            check("b2b_w1_busy", busy, 1);
`ifndef SERIALIZER_SKID_EN
            check("b2b_rdy_shift", din_ready, 0);
`endif
            g1[i] = ser_out;
            @(negedge t_clk);
`ifdef SERIALIZER_SKID_EN
            if (i == 0) din_valid = 1'b0;
`endif
        end
        check("b2b_gap_frm", frm_rst, 1);
        check("b2b_gap_busy", busy, 0);
        check("b2b_gap_ser", ser_out, 0);
        @(negedge t_clk);
        din_valid = 1'b0;
        g2 = '0;
        for (int i = 0; i < W; i++) begin
            check("b2b_w2_busy", busy, 1);
            check("b2b_w2_frm", frm_rst, 0);
            g2[i] = ser_out;
            @(negedge t_clk);
        end
        check("b2b_w1", g1, 8'h01);
        check("b2b_w2", g2, 8'hFF);
        check("b2b_end_frm", frm_rst, 1);

`ifdef SERIALIZER_SKID_EN
        // 4. skid: second word offered in cycle 3 of SHIFT
        @(negedge t_clk);
        din = 8'hA5;
        din_valid = 1'b1;
        @(negedge t_clk);
        din_valid = 1'b0;
        g1 = '0;
        for (int i = 0; i < W; i++) begin
            if (i == 2) begin
                din = 8'h3C;
                din_valid = 1'b1;
                check("sk_rdy_offer", din_ready, 1);
            end
            if (i == 3) din_valid = 1'b0;
            if (i >= 3) check("sk_rdy_full", din_ready, 0);
            g1[i] = ser_out;
            @(negedge t_clk);
        end
        check("sk_gap_frm", frm_rst, 1);
        check("sk_gap_busy", busy, 0);
        check("sk_gap_rdy", din_ready, 0);
        @(negedge t_clk);
        check("sk_drained_rdy", din_ready, 1);
        g2 = '0;
        for (int i = 0; i < W; i++) begin
            check("sk_w2_busy", busy, 1);
            g2[i] = ser_out;
            @(negedge t_clk);
        end
        check("sk_w1", g1, 8'hA5);
        check("sk_w2", g2, 8'h3C);
`endif

        // 5. asynchronous reset during bit 4 of 8'hF0
        @(negedge t_clk);
        din = 8'hF0;
        din_valid = 1'b1;
        @(negedge t_clk);
        din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef SERIALIZER_SKID_EN
            if (i == 1) begin
                din = 8'h55;
                din_valid = 1'b1;
            end
            if (i == 2) din_valid = 1'b0;
`endif
            @(negedge t_clk);
        end
        check("mid_bit4", ser_out, 1);
        check("mid_busy", busy, 1);
        #2 r_n = 1'b0;
        #1;
        check("arst_ser", ser_out, 0);
        check("arst_frm", frm_rst, 1);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge t_clk);
        @(negedge t_clk);
        r_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge t_clk);
            check("post_busy", busy, 0);
            check("post_ser", ser_out, 0);
            check("post_frm", frm_rst, 1);
            check("post_rdy", din_ready, 1);
        end

        // 6. edge values
        send_word(8'h00, "w00", g1);
        check("w00_bits", g1, 8'h00);
        send_word(8'h80, "w80", g2);
        check("w80_bits", g2, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
